// File: rtl/msi_snoop_responder.sv
// Snoop-side responder for a 4-line direct-mapped MSI cache: looks up bus snoops,
// downgrades or invalidates lines, and offers modified data back to memory.
module msi_snoop_responder #(
    parameter logic [1:0] MY_ID = 2'd0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       bus_valid,
    input  logic [1:0] bus_op,
    input  logic [1:0] bus_src,
    input  logic [4:0] bus_addr,
    output logic       bus_ready,
    input  logic       loc_we,
    input  logic [1:0] loc_index,
    input  logic [2:0] loc_tag,
    input  logic [1:0] loc_state,
    input  logic [7:0] loc_data,
    output logic       loc_nack,
    output logic       flush_valid,
    output logic [4:0] flush_addr,
    output logic [7:0] flush_data,
    input  logic       flush_ack,
    output logic       inv_pulse,
    output logic       busy,
    output logic [7:0] line_state
);

    typedef enum logic [1:0] {IDLE, LOOKUP, FLUSH} state_e;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] BUS_RD  = 2'b01;
    localparam logic [1:0] ST_I    = 2'b00;
    localparam logic [1:0] ST_S    = 2'b01;
    localparam logic [1:0] ST_M    = 2'b10;

    state_e     state_q;
    logic [1:0] op_q;
    logic [4:0] addr_q;
    logic [1:0] st_q  [4];
    logic [2:0] tag_q [4];
    logic [7:0] dat_q [4];
    logic       ready_q, nack_q, fvalid_q, inv_q;
    logic [4:0] faddr_q;
    logic [7:0] fdata_q;

    logic [1:0] cap_idx_d;
    logic [2:0] cap_tag_d;
    logic       hit_d, idle_snoop_d, foreign_d, loc_block_d;
    logic [1:0] loc_state_d;

    assign cap_idx_d = addr_q[1:0];
    assign cap_tag_d = addr_q[4:2];
    assign hit_d     = (st_q[cap_idx_d] != ST_I) && (tag_q[cap_idx_d] == cap_tag_d);

    // The cycle bus_ready is high still carries the finished snoop's bus_valid,
    // so it must not be taken as a new request.
    assign idle_snoop_d = (state_q == IDLE) && bus_valid && !ready_q;
    assign foreign_d    = (bus_src != MY_ID) && (bus_op != OP_NONE);
    assign loc_block_d  = loc_we && (state_q != IDLE) && (loc_index == cap_idx_d);
    assign loc_state_d  = (loc_state == 2'b11) ? ST_I : loc_state;

    assign bus_ready   = ready_q | (idle_snoop_d && !foreign_d);
    assign loc_nack    = nack_q;
    assign flush_valid = fvalid_q;
    assign flush_addr  = faddr_q;
    assign flush_data  = fdata_q;
    assign inv_pulse   = inv_q;
    assign busy        = (state_q != IDLE);
    assign line_state  = {st_q[3], st_q[2], st_q[1], st_q[0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_NONE;
            addr_q   <= '0;
            ready_q  <= 1'b0;
            nack_q   <= 1'b0;
            fvalid_q <= 1'b0;
            inv_q    <= 1'b0;
            faddr_q  <= '0;
            fdata_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= ST_I;
                tag_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            inv_q   <= 1'b0;
            nack_q  <= 1'b0;

            // The line under snoop is locked; the FSM alone may touch it while busy.
            if (loc_we) begin
                if (loc_block_d) begin
                    nack_q <= 1'b1;
                end else begin
                    st_q[loc_index]  <= loc_state_d;
                    tag_q[loc_index] <= loc_tag;
                    dat_q[loc_index] <= loc_data;
                end
            end

            case (state_q)
                IDLE: begin
                    if (idle_snoop_d && foreign_d) begin
                        op_q    <= bus_op;
                        addr_q  <= bus_addr;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_d && st_q[cap_idx_d] == ST_M) begin
                        fvalid_q <= 1'b1;
                        faddr_q  <= addr_q;
                        fdata_q  <= dat_q[cap_idx_d];
                        state_q  <= FLUSH;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                        if (hit_d && op_q != BUS_RD) begin
                            st_q[cap_idx_d] <= ST_I;
                            inv_q           <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_ack) begin
                        fvalid_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= IDLE;
                        if (op_q == BUS_RD) begin
                            st_q[cap_idx_d] <= ST_S;
                        end else begin
                            st_q[cap_idx_d] <= ST_I;
                            inv_q           <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msi_snoop_responder.sv
// Directed bench for msi_snoop_responder: hand-computed line states and handshake timing.
module tb_msi_snoop_responder;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       bus_valid;
    logic [1:0] bus_op;
    logic [1:0] bus_src;
    logic [4:0] bus_addr;
    logic       bus_ready;
    logic       loc_we;
    logic [1:0] loc_index;
    logic [2:0] loc_tag;
    logic [1:0] loc_state;
    logic [7:0] loc_data;
    logic       loc_nack;
    logic       flush_valid;
    logic [4:0] flush_addr;
    logic [7:0] flush_data;
    logic       flush_ack;
    logic       inv_pulse;
    logic       busy;
    logic [7:0] line_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    int n;

    msi_snoop_responder #(.MY_ID(2'd0)) dut (
        .clock(clock), .reset_n(reset_n),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_src(bus_src), .bus_addr(bus_addr),
        .bus_ready(bus_ready),
        .loc_we(loc_we), .loc_index(loc_index), .loc_tag(loc_tag), .loc_state(loc_state),
        .loc_data(loc_data), .loc_nack(loc_nack),
        .flush_valid(flush_valid), .flush_addr(flush_addr), .flush_data(flush_data),
        .flush_ack(flush_ack), .inv_pulse(inv_pulse), .busy(busy), .line_state(line_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic local_write(input logic [1:0] idx, input logic [2:0] tag,
                               input logic [1:0] st, input logic [7:0] d);
        @(negedge clock);
        loc_we = 1'b1; loc_index = idx; loc_tag = tag; loc_state = st; loc_data = d;
        @(negedge clock);
        loc_we = 1'b0;
    endtask

    task automatic snoop(input logic [1:0] op, input logic [1:0] src, input logic [4:0] addr);
        @(negedge clock);
        bus_valid = 1'b1; bus_op = op; bus_src = src; bus_addr = addr;
    endtask

    // Counts negedges until bus_ready is seen; 99 if it never arrives.
    task automatic wait_ready(output int cycles);
        cycles = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (bus_ready) begin cycles = i; break; end
        end
    endtask

    task automatic wait_flush(output int cycles);
        cycles = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (flush_valid) begin cycles = i; break; end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; bus_valid = 0; bus_op = 0; bus_src = 0; bus_addr = 0;
        loc_we = 0; loc_index = 0; loc_tag = 0; loc_state = 0; loc_data = 0; flush_ack = 0;
        repeat (2) @(negedge clock);
        total_cnt++; if (line_state !== 8'h00) $display("FAIL rst_lines: got %h required %h", line_state, 8'h00); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (flush_valid !== 1'b0) $display("FAIL rst_fvalid: got %b required 0", flush_valid); else pass_cnt++;
        total_cnt++; if (bus_ready !== 1'b0 || inv_pulse !== 1'b0 || loc_nack !== 1'b0)
            $display("FAIL rst_pulses: got ready=%b inv=%b nack=%b required 0", bus_ready, inv_pulse, loc_nack); else pass_cnt++;
        total_cnt++; if (flush_addr !== 5'h00 || flush_data !== 8'h00)
            $display("FAIL rst_flush_bus: got addr=%h data=%h required 0", flush_addr, flush_data); else pass_cnt++;
        reset_n = 1'b1;
    endtask

    task automatic test_local_write;
        local_write(2'd3, 3'd0, 2'b11, 8'hFF);
        total_cnt++; if (line_state !== 8'h00) $display("FAIL lw_state11: got %h required %h", line_state, 8'h00); else pass_cnt++;
        local_write(2'd3, 3'd0, 2'b01, 8'hFF);
        total_cnt++; if (line_state !== 8'h40) $display("FAIL lw_shared: got %h required %h", line_state, 8'h40); else pass_cnt++;
        local_write(2'd3, 3'd0, 2'b00, 8'h00);
        total_cnt++; if (line_state !== 8'h00) $display("FAIL lw_clear: got %h required %h", line_state, 8'h00); else pass_cnt++;
    endtask

    task automatic test_flush_read;
        local_write(2'd1, 3'd5, 2'b10, 8'hA7);
        total_cnt++; if (line_state !== 8'h08) $display("FAIL fr_setup: got %h required %h", line_state, 8'h08); else pass_cnt++;
        snoop(2'b01, 2'd1, 5'h15);
        wait_flush(n);
        total_cnt++; if (n !== 2) $display("FAIL fr_latency: got %0d required 2", n); else pass_cnt++;
        total_cnt++; if (flush_addr !== 5'h15 || flush_data !== 8'hA7)
            $display("FAIL fr_payload: got addr=%h data=%h required 15/a7", flush_addr, flush_data); else pass_cnt++;
        total_cnt++; if (bus_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL fr_wait_flags: got ready=%b busy=%b required 0/1", bus_ready, busy); else pass_cnt++;
        repeat (3) @(negedge clock);
        total_cnt++; if (flush_valid !== 1'b1 || flush_data !== 8'hA7 || flush_addr !== 5'h15)
            $display("FAIL fr_hold: got v=%b addr=%h data=%h required 1/15/a7", flush_valid, flush_addr, flush_data); else pass_cnt++;
        flush_ack = 1'b1;
        @(negedge clock);
        flush_ack = 1'b0;
        total_cnt++; if (bus_ready !== 1'b1 || flush_valid !== 1'b0 || inv_pulse !== 1'b0)
            $display("FAIL fr_ack: got ready=%b fv=%b inv=%b required 1/0/0", bus_ready, flush_valid, inv_pulse); else pass_cnt++;
        total_cnt++; if (line_state !== 8'h04) $display("FAIL fr_to_shared: got %h required %h", line_state, 8'h04); else pass_cnt++;
        bus_valid = 1'b0;
        @(negedge clock);
        total_cnt++; if (bus_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL fr_after: got ready=%b busy=%b required 0/0", bus_ready, busy); else pass_cnt++;
    endtask

    task automatic test_invalidate;
        local_write(2'd2, 3'd3, 2'b01, 8'h11);
        total_cnt++; if (line_state !== 8'h14) $display("FAIL inv_setup: got %h required %h", line_state, 8'h14); else pass_cnt++;
        snoop(2'b10, 2'd1, 5'h0E);
        @(negedge clock);
        total_cnt++; if (bus_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL inv_lookup: got ready=%b busy=%b required 0/1", bus_ready, busy); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (bus_ready !== 1'b1 || inv_pulse !== 1'b1)
            $display("FAIL inv_done: got ready=%b inv=%b required 1/1", bus_ready, inv_pulse); else pass_cnt++;
        total_cnt++; if (line_state !== 8'h04 || flush_valid !== 1'b0)
            $display("FAIL inv_line: got %h fv=%b required 04/0", line_state, flush_valid); else pass_cnt++;
        bus_valid = 1'b0;
        @(negedge clock);
        total_cnt++; if (bus_ready !== 1'b0 || inv_pulse !== 1'b0)
            $display("FAIL inv_pulse_width: got ready=%b inv=%b required 0/0", bus_ready, inv_pulse); else pass_cnt++;
    endtask

    task automatic test_own_id;
        local_write(2'd0, 3'd1, 2'b10, 8'hC3);
        total_cnt++; if (line_state !== 8'h06) $display("FAIL own_setup: got %h required %h", line_state, 8'h06); else pass_cnt++;
        snoop(2'b10, 2'd0, 5'h04);
        #1;
        total_cnt++; if (bus_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL own_ready: got ready=%b busy=%b required 1/0", bus_ready, busy); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (busy !== 1'b0 || line_state !== 8'h06 || flush_valid !== 1'b0)
            $display("FAIL own_nochange: got busy=%b lines=%h fv=%b required 0/06/0", busy, line_state, flush_valid); else pass_cnt++;
        bus_op = 2'b00; bus_src = 2'd2;
        #1;
        total_cnt++; if (bus_ready !== 1'b1) $display("FAIL opnone_ready: got %b required 1", bus_ready); else pass_cnt++;
        @(negedge clock);
        bus_valid = 1'b0;
        #1;
        total_cnt++; if (bus_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL opnone_after: got ready=%b busy=%b required 0/0", bus_ready, busy); else pass_cnt++;
    endtask

    task automatic test_miss;
        snoop(2'b01, 2'd2, 5'h08);
        wait_ready(n);
        total_cnt++; if (n !== 2) $display("FAIL miss_latency: got %0d required 2", n); else pass_cnt++;
        total_cnt++; if (line_state !== 8'h06 || inv_pulse !== 1'b0 || flush_valid !== 1'b0)
            $display("FAIL miss_line: got %h inv=%b fv=%b required 06/0/0", line_state, inv_pulse, flush_valid); else pass_cnt++;
        bus_valid = 1'b0;
    endtask

    task automatic test_flush_window;
        local_write(2'd1, 3'd5, 2'b10, 8'h5A);
        total_cnt++; if (line_state !== 8'h0A) $display("FAIL fw_setup: got %h required %h", line_state, 8'h0A); else pass_cnt++;
        snoop(2'b10, 2'd3, 5'h15);
        wait_flush(n);
        total_cnt++; if (n !== 2) $display("FAIL fw_latency: got %0d required 2", n); else pass_cnt++;
        loc_we = 1'b1; loc_index = 2'd1; loc_tag = 3'd5; loc_state = 2'b01; loc_data = 8'h00;
        @(negedge clock);
        total_cnt++; if (loc_nack !== 1'b1 || line_state !== 8'h0A)
            $display("FAIL fw_nack: got nack=%b lines=%h required 1/0a", loc_nack, line_state); else pass_cnt++;
        loc_index = 2'd3; loc_tag = 3'd2; loc_state = 2'b01; loc_data = 8'h3C;
        @(negedge clock);
        loc_we = 1'b0;
        total_cnt++; if (loc_nack !== 1'b0 || line_state !== 8'h4A)
            $display("FAIL fw_other_idx: got nack=%b lines=%h required 0/4a", loc_nack, line_state); else pass_cnt++;
        total_cnt++; if (flush_valid !== 1'b1 || flush_data !== 8'h5A || busy !== 1'b1)
            $display("FAIL fw_hold: got fv=%b data=%h busy=%b required 1/5a/1", flush_valid, flush_data, busy); else pass_cnt++;
        flush_ack = 1'b1;
        @(negedge clock);
        flush_ack = 1'b0;
        total_cnt++; if (bus_ready !== 1'b1 || inv_pulse !== 1'b1 || flush_valid !== 1'b0)
            $display("FAIL fw_ack: got ready=%b inv=%b fv=%b required 1/1/0", bus_ready, inv_pulse, flush_valid); else pass_cnt++;
        total_cnt++; if (line_state !== 8'h42) $display("FAIL fw_line: got %h required %h", line_state, 8'h42); else pass_cnt++;
        bus_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        local_write(2'd2, 3'd3, 2'b01, 8'h77);
        snoop(2'b01, 2'd1, 5'h0E);
        wait_ready(n);
        total_cnt++; if (n !== 2 || inv_pulse !== 1'b0 || line_state !== 8'h52)
            $display("FAIL b2b_rd_shared: got n=%0d inv=%b lines=%h required 2/0/52", n, inv_pulse, line_state); else pass_cnt++;
        bus_valid = 1'b0;
        snoop(2'b11, 2'd2, 5'h0E);
        wait_ready(n);
        total_cnt++; if (n !== 2 || inv_pulse !== 1'b1 || line_state !== 8'h42)
            $display("FAIL b2b_upgr: got n=%0d inv=%b lines=%h required 2/1/42", n, inv_pulse, line_state); else pass_cnt++;
        bus_valid = 1'b0;
    endtask

    task automatic test_reset_mid_flush;
        snoop(2'b01, 2'd1, 5'h04);
        wait_flush(n);
        total_cnt++; if (n !== 2 || flush_data !== 8'hC3)
            $display("FAIL rmf_flush: got n=%0d data=%h required 2/c3", n, flush_data); else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        total_cnt++; if (flush_valid !== 1'b0 || busy !== 1'b0 || line_state !== 8'h00)
            $display("FAIL rmf_abort: got fv=%b busy=%b lines=%h required 0/0/00", flush_valid, busy, line_state); else pass_cnt++;
        bus_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        local_write(2'd2, 3'd3, 2'b01, 8'h11);
        snoop(2'b11, 2'd1, 5'h0E);
        wait_ready(n);
        total_cnt++; if (n !== 2 || inv_pulse !== 1'b1 || line_state !== 8'h00)
            $display("FAIL rmf_resume: got n=%0d inv=%b lines=%h required 2/1/00", n, inv_pulse, line_state); else pass_cnt++;
        bus_valid = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        test_reset;
        test_local_write;
        test_flush_read;
        test_invalidate;
        test_own_id;
        test_miss;
        test_flush_window;
        test_back_to_back;
        test_reset_mid_flush;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
